// File: rtl/uart_tx_arbiter_if.sv
// Wishbone master-side bundle between uart_tx_arbiter and the UART register aperture.
interface uart_tx_arbiter_if #(
  parameter int ADDRWIDTH = 10,
  parameter int DATAWIDTH = 32
);
  logic [ADDRWIDTH-1:0] WBm_ADR_o;
  logic                 WBm_CYC_o;
  logic                 WBm_STB_o;
  logic                 WBm_WE_o;
  logic [3:0]           WBm_SEL_o;
  logic [DATAWIDTH-1:0] WBm_DAT_o;
  logic [DATAWIDTH-1:0] WBm_DAT_i;
  logic                 WBm_ACK_i;

  modport master (
    output WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_SEL_o, WBm_DAT_o,
    input  WBm_DAT_i, WBm_ACK_i
  );

  modport slave (
    input  WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_SEL_o, WBm_DAT_o,
    output WBm_DAT_i, WBm_ACK_i
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter that feeds bytes from NUM_REQ producers
// into a UART THR over Wishbone, polling LSR.THRE for FIFO space.
module uart_tx_arbiter #(
  parameter int                   NUM_REQ      = 4,
  parameter int                   ADDRWIDTH    = 10,
  parameter int                   DATAWIDTH    = 32,
  parameter logic [ADDRWIDTH-1:0] THR_OFFSET   = 10'h000,
  parameter logic [ADDRWIDTH-1:0] LSR_OFFSET   = 10'h014,
  parameter int                   LSR_THRE_BIT = 5,
  parameter int                   BURST_MAX    = 16,
  parameter int                   POLL_GAP     = 64,
  parameter int                   LOCK_TIMEOUT = 1024
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 lock_timeout_o,
  output logic                 busy_o,
  uart_tx_arbiter_if.master    wbm
);
  localparam int unsigned NR = NUM_REQ;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POLL  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_ARB   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]           r_state, w_state_nxt;
  logic [CW-1:0]        r_credit;
  logic                 r_locked;
  logic [IW-1:0]        r_owner, r_rr_ptr, r_sel;
  logic [GW-1:0]        r_gap_cnt;
  logic [TW-1:0]        r_to_cnt;
  logic                 r_timeout, r_busy;
  logic [NUM_REQ-1:0]   r_grant;
  logic [ADDRWIDTH-1:0] r_adr;
  logic                 r_cyc, r_stb, r_we;
  logic [3:0]           r_be;
  logic [DATAWIDTH-1:0] r_dat;

  logic [IW-1:0] w_rr_sel, w_cand, w_sel;
  logic          w_rr_hit, w_sel_valid, w_eligible, w_ack, w_thre, w_to_fire;
  logic [7:0]    w_sel_byte;
  logic          w_unused_ok;

  function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_rr_sel = r_rr_ptr;
    w_rr_hit = 1'b0;
    w_cand   = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      w_cand = IW'((32'(r_rr_ptr) + k) % NR);
      if (!w_rr_hit && req_valid_i[w_cand]) begin
        w_rr_hit = 1'b1;
        w_rr_sel = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_byte = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (w_sel == IW'(k)) w_sel_byte = req_data_i[8*k +: 8];
    end
  end

  assign w_sel       = r_locked ? r_owner : w_rr_sel;
  assign w_sel_valid = req_valid_i[w_sel];
  assign w_eligible  = r_locked ? req_valid_i[r_owner] : |req_valid_i;
  assign w_ack       = wbm.WBm_ACK_i;
  assign w_thre      = wbm.WBm_DAT_i[LSR_THRE_BIT];
  assign w_to_fire   = r_locked && !req_valid_i[r_owner] && (r_to_cnt == TW'(LOCK_TIMEOUT - 1));
  assign w_unused_ok = &{1'b0, wbm.WBm_DAT_i};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_eligible) w_state_nxt = (r_credit == '0) ? S_POLL : S_ARB;
      S_POLL:  if (w_ack) w_state_nxt = w_thre ? S_ARB : S_GAP;
      S_GAP:   if (r_gap_cnt == GW'(POLL_GAP - 1)) w_state_nxt = S_IDLE;
      S_ARB:   w_state_nxt = w_sel_valid ? S_WRITE : S_IDLE;
      S_WRITE: if (w_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ready is the only combinational output; reset suppresses it even if ACK arrives.
  always_comb begin
    req_ready_o = '0;
    if (r_state == S_WRITE && w_ack && !WBs_RST_i) req_ready_o[r_sel] = 1'b1;
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      r_state   <= S_IDLE;
      r_credit  <= '0;
      r_locked  <= 1'b0;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_sel     <= '0;
      r_gap_cnt <= '0;
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      r_grant   <= '0;
      r_adr     <= '0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_dat     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);

      if (r_locked && !req_valid_i[r_owner]) r_to_cnt <= r_to_cnt + 1'b1;
      else                                   r_to_cnt <= '0;

      if (w_to_fire) begin
        r_locked  <= 1'b0;
        r_grant   <= '0;
        r_timeout <= 1'b1;
        r_rr_ptr  <= f_next(r_owner);
        r_to_cnt  <= '0;
      end

      case (r_state)
        S_IDLE: if (w_eligible && r_credit == '0) begin
          r_cyc <= 1'b1;
          r_stb <= 1'b1;
          r_we  <= 1'b0;
          r_adr <= LSR_OFFSET;
          r_be  <= 4'b0001;
        end
        S_POLL: if (w_ack) begin
          r_cyc     <= 1'b0;
          r_stb     <= 1'b0;
          r_gap_cnt <= '0;
          if (w_thre) r_credit <= CW'(BURST_MAX);
        end
        S_GAP: r_gap_cnt <= r_gap_cnt + 1'b1;
        S_ARB: if (w_sel_valid) begin
          r_sel <= w_sel;
          r_dat <= {{(DATAWIDTH-8){1'b0}}, w_sel_byte};
          r_cyc <= 1'b1;
          r_stb <= 1'b1;
          r_we  <= 1'b1;
          r_adr <= THR_OFFSET;
          r_be  <= 4'b0001;
        end
        S_WRITE: if (w_ack) begin
          r_cyc    <= 1'b0;
          r_stb    <= 1'b0;
          r_we     <= 1'b0;
          r_credit <= r_credit - 1'b1;
          if (req_last_i[r_sel]) begin
            r_locked <= 1'b0;
            r_grant  <= '0;
            r_rr_ptr <= f_next(r_sel);
          end else begin
            r_locked <= 1'b1;
            r_owner  <= r_sel;
            r_grant  <= NUM_REQ'(1) << r_sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_o        = r_grant;
  assign lock_timeout_o = r_timeout;
  assign busy_o         = r_busy;
  assign wbm.WBm_ADR_o  = r_adr;
  assign wbm.WBm_CYC_o  = r_cyc;
  assign wbm.WBm_STB_o  = r_stb;
  assign wbm.WBm_WE_o   = r_we;
  assign wbm.WBm_SEL_o  = r_be;
  assign wbm.WBm_DAT_o  = r_dat;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a zero-wait Wishbone UART model and per-requester byte queues.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int PG = 64;
  localparam int LT = 1024;
  localparam int BM = 16;
  localparam logic [9:0] LSR = 10'h014;
  localparam logic [9:0] THR = 10'h000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]   req_valid = '0, req_last = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_ready, grant;
  logic            lock_to, busy;
  logic            ack_en = 1'b1;

  uart_tx_arbiter_if #(.ADDRWIDTH(10), .DATAWIDTH(32)) wb ();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .ADDRWIDTH(10), .DATAWIDTH(32), .THR_OFFSET(THR), .LSR_OFFSET(LSR),
    .LSR_THRE_BIT(5), .BURST_MAX(BM), .POLL_GAP(PG), .LOCK_TIMEOUT(LT)
  ) dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .grant_o(grant), .lock_timeout_o(lock_to), .busy_o(busy),
    .wbm(wb)
  );

  // UART model: zero-wait ACK, LSR reads follow a scripted sequence then report THRE=1.
  logic [31:0] lsr_seq [4];
  int lsr_n = 0, lsr_idx = 0;
  assign wb.WBm_ACK_i = wb.WBm_CYC_o & wb.WBm_STB_o & ack_en;
  assign wb.WBm_DAT_i = (lsr_idx < lsr_n) ? lsr_seq[lsr_idx] : 32'h20;

  logic [8:0] rq [NR][$];
  logic [NR-1:0] drv_p;
  logic drv_rd;

  // Requester model: bytes leave the queue only after the edge that consumed them.
  always begin
    @(negedge clk);
    drv_p  = req_ready;
    drv_rd = wb.WBm_CYC_o & wb.WBm_STB_o & wb.WBm_ACK_i & ~wb.WBm_WE_o;
    @(posedge clk);
    #1;
    if (drv_rd) lsr_idx++;
    for (int i = 0; i < NR; i++) begin
      if (drv_p[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      req_valid[i]       = (rq[i].size() != 0);
      req_data[8*i +: 8] = (rq[i].size() != 0) ? rq[i][0][7:0] : 8'h00;
      req_last[i]        = (rq[i].size() != 0) ? rq[i][0][8] : 1'b0;
    end
  end

  typedef struct { logic we; logic [9:0] adr; logic [31:0] dat; int cyc; logic [3:0] who; } ev_t;
  ev_t mon_ev;
  ev_t log_q[$];
  logic [3:0] gnt_q[$];
  int cyc = 0, rdy_cnt = 0;
  logic gpend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (gpend) begin
      gnt_q.push_back(grant);
      gpend = 1'b0;
    end
    if (|req_ready) rdy_cnt++;
    if (wb.WBm_CYC_o && wb.WBm_STB_o && wb.WBm_ACK_i) begin
      mon_ev.we  = wb.WBm_WE_o;
      mon_ev.adr = wb.WBm_ADR_o;
      mon_ev.dat = wb.WBm_WE_o ? wb.WBm_DAT_o : wb.WBm_DAT_i;
      mon_ev.cyc = cyc;
      mon_ev.who = req_ready;
      log_q.push_back(mon_ev);
      if (wb.WBm_WE_o) gpend = 1'b1;
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string nm, input int maxc);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
      done = all_empty() && !busy && !wb.WBm_CYC_o;
    end
    chk({"idle_", nm}, 32'(done), 32'd1);
  endtask

  task automatic wait_log(input string nm, input int cnt, input int maxc);
    int n = 0;
    while (log_q.size() < cnt && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({"log_", nm}, 32'(log_q.size() >= cnt), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ack_en = 1'b1;
    lsr_n = 0;
    lsr_idx = 0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    gnt_q.delete();
  endtask

  typedef struct {
    int phase; int req; logic [7:0] dat; logic last;
    logic [31:0] exp_dat; logic [3:0] exp_who; logic [3:0] exp_grant;
  } vec_t;
  vec_t vt[9];

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nw, nr, w_cyc, k, ws;
    vt[0] = '{0, 0, 8'h41, 1'b0, 32'h41, 4'b0001, 4'b0001};
    vt[1] = '{0, 0, 8'h42, 1'b0, 32'h42, 4'b0001, 4'b0001};
    vt[2] = '{0, 0, 8'h43, 1'b1, 32'h43, 4'b0001, 4'b0000};
    vt[3] = '{1, 1, 8'hA1, 1'b0, 32'hA1, 4'b0010, 4'b0010};
    vt[4] = '{1, 1, 8'hA2, 1'b1, 32'hA2, 4'b0010, 4'b0000};
    vt[5] = '{1, 2, 8'hB1, 1'b0, 32'hB1, 4'b0100, 4'b0100};
    vt[6] = '{1, 2, 8'hB2, 1'b1, 32'hB2, 4'b0100, 4'b0000};
    vt[7] = '{2, 3, 8'hD3, 1'b1, 32'hD3, 4'b1000, 4'b0000};
    vt[8] = '{2, 0, 8'hC0, 1'b1, 32'hC0, 4'b0001, 4'b0000};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(wb.WBm_CYC_o), 0);
    chk("rst_stb", 32'(wb.WBm_STB_o), 0);
    chk("rst_we", 32'(wb.WBm_WE_o), 0);
    chk("rst_adr", 32'(wb.WBm_ADR_o), 0);
    chk("rst_dat", wb.WBm_DAT_o, 0);
    chk("rst_sel", 32'(wb.WBm_SEL_o), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_lockto", 32'(lock_to), 0);
    chk("rst_busy", 32'(busy), 0);

    // THRE=0 twice: polls spaced by the gap, write only after the third poll
    do_reset();
    lsr_seq[0] = 32'h0; lsr_seq[1] = 32'h0; lsr_seq[2] = 32'h20;
    lsr_n = 3; lsr_idx = 0;
    rq[0].push_back({1'b1, 8'h55});
    wait_idle("poll", 600);
    chk("poll_events", 32'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("poll_we%0d", i), 32'(log_q[i].we), 0);
        chk($sformatf("poll_adr%0d", i), 32'(log_q[i].adr), 32'(LSR));
      end
      chk_range("poll_gap1", log_q[1].cyc - log_q[0].cyc, PG + 1, PG + 8);
      chk_range("poll_gap2", log_q[2].cyc - log_q[1].cyc, PG + 1, PG + 8);
      chk("poll_wr_we", 32'(log_q[3].we), 1);
      chk("poll_wr_adr", 32'(log_q[3].adr), 32'(THR));
      chk("poll_wr_dat", log_q[3].dat, 32'h55);
    end

    // Table: locked messages, round-robin order, rr_ptr follow-on
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 9; i++)
        if (vt[i].phase == p) rq[vt[i].req].push_back({vt[i].last, vt[i].dat});
      wait_idle($sformatf("phase%0d", p), 300);
    end
    @(negedge clk);
    nw = 0; nr = 0;
    foreach (log_q[i]) begin
      if (log_q[i].we) begin
        if (nw < 9) begin
          chk($sformatf("vec%0d_dat", nw), log_q[i].dat, vt[nw].exp_dat);
          chk($sformatf("vec%0d_who", nw), 32'(log_q[i].who), 32'(vt[nw].exp_who));
          if (nw < gnt_q.size())
            chk($sformatf("vec%0d_grant", nw), 32'(gnt_q[nw]), 32'(vt[nw].exp_grant));
        end
        nw++;
      end else nr++;
    end
    chk("vec_writes", 32'(nw), 9);
    chk("vec_grants", 32'(gnt_q.size()), 9);
    chk("vec_reads", 32'(nr), 1);

    // 20 unlocked bytes: credit exhausted after 16 writes
    do_reset();
    for (int i = 0; i < 20; i++) rq[0].push_back({1'b1, 8'(8'h80 + i)});
    wait_idle("burst", 800);
    chk("burst_events", 32'(log_q.size()), 22);
    if (log_q.size() == 22) begin
      chk("burst_first_read", 32'(log_q[0].we), 0);
      k = 0;
      for (int i = 1; i <= 16; i++) if (log_q[i].we) k++;
      chk("burst_writes_before_poll", 32'(k), 16);
      chk("burst_second_read", 32'(log_q[17].we), 0);
      chk("burst_second_adr", 32'(log_q[17].adr), 32'(LSR));
      chk("burst_last_dat", log_q[21].dat, 32'h93);
    end

    // Lock timeout: owner r0 goes quiet mid-message, r2 waits
    do_reset();
    rq[0].push_back({1'b0, 8'h61});
    rq[2].push_back({1'b1, 8'h62});
    wait_log("to_first", 2, 200);
    w_cyc = (log_q.size() >= 2) ? log_q[1].cyc : cyc;
    if (log_q.size() >= 2) chk("to_first_dat", log_q[1].dat, 32'h61);
    repeat (500) @(negedge clk);
    chk("to_held_events", 32'(log_q.size()), 2);
    chk("to_held_grant", 32'(grant), 32'b0001);
    chk("to_held_flag", 32'(lock_to), 0);
    k = 0;
    while (!lock_to && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("to_flag", 32'(lock_to), 1);
    chk_range("to_cycles", cyc - w_cyc, LT, LT + 2);
    chk("to_grant", 32'(grant), 0);
    wait_idle("to_r2", 100);
    chk("to_events", 32'(log_q.size()), 3);
    if (log_q.size() == 3) begin
      chk("to_r2_dat", log_q[2].dat, 32'h62);
      chk("to_r2_who", 32'(log_q[2].who), 32'b0100);
    end
    chk("to_sticky", 32'(lock_to), 1);

    // Reset while WRITE waits for ACK
    ack_en = 1'b0;
    rq[1].push_back({1'b1, 8'h77});
    k = 0;
    while (!(wb.WBm_CYC_o && wb.WBm_STB_o && wb.WBm_WE_o) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rw_in_write", 32'(wb.WBm_CYC_o & wb.WBm_STB_o & wb.WBm_WE_o), 1);
    ws = rdy_cnt;
    #2;
    rst = 1'b1;
    ack_en = 1'b1;
    #1;
    chk("rw_ready_in_reset", 32'(req_ready), 0);
    @(negedge clk);
    chk("rw_cyc", 32'(wb.WBm_CYC_o), 0);
    chk("rw_stb", 32'(wb.WBm_STB_o), 0);
    chk("rw_no_pulse", 32'(rdy_cnt - ws), 0);
    rst = 1'b0;
    log_q.delete();
    gnt_q.delete();
    wait_idle("rw_after", 100);
    chk("rw_events", 32'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      chk("rw_first_we", 32'(log_q[0].we), 0);
      chk("rw_first_adr", 32'(log_q[0].adr), 32'(LSR));
      chk("rw_wr_dat", log_q[1].dat, 32'h77);
      chk("rw_wr_who", 32'(log_q[1].who), 32'b0010);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
